// File: rtl/rf_exec_pkg.sv
// Shared definitions for the register-file execution controller: widths, opcodes, FSM states.
// Optional build macro RF_EXEC_CARRY_CHAIN_EN remaps opcodes 5/7 to ADC/SBB.
package rf_exec_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned AW_DEF = 2;
    localparam int unsigned OPW    = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'd0;
    localparam logic [OPW-1:0] OP_SUB  = 3'd1;
    localparam logic [OPW-1:0] OP_AND  = 3'd2;
    localparam logic [OPW-1:0] OP_OR   = 3'd3;
    localparam logic [OPW-1:0] OP_XOR  = 3'd4;
    localparam logic [OPW-1:0] OP_MOV  = 3'd5;
    localparam logic [OPW-1:0] OP_LDI  = 3'd6;
    localparam logic [OPW-1:0] OP_SHL1 = 3'd7;
    // Carry-chain build reuses the MOV/SHL1 encodings.
    localparam logic [OPW-1:0] OP_ADC  = 3'd5;
    localparam logic [OPW-1:0] OP_SBB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_exec_alu.sv
// Combinational ALU for rf_exec_ctrl; cout_valid marks ops that update the carry flag.
// RF_EXEC_CARRY_CHAIN_EN selects ADC/SBB in place of MOV/SHL1.
module rf_exec_alu
    import rf_exec_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [DW-1:0]  imm,
    input  logic           cin,
    output logic [DW-1:0]  res,
    output logic           cout,
    output logic           cout_valid
);

    logic [DW:0] ext;

`ifndef RF_EXEC_CARRY_CHAIN_EN
    logic unused_cin;
    assign unused_cin = cin;
`endif

    always_comb begin
        res        = '0;
        cout       = 1'b0;
        cout_valid = 1'b0;
        ext        = '0;
        case (op)
            OP_ADD: begin
                ext        = {1'b0, a} + {1'b0, b};
                res        = ext[DW-1:0];
                cout       = ext[DW];
                cout_valid = 1'b1;
            end
            OP_SUB: begin
                // Bit DW of the extended difference is the unsigned borrow.
                ext        = {1'b0, a} - {1'b0, b};
                res        = ext[DW-1:0];
                cout       = ext[DW];
                cout_valid = 1'b1;
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_LDI: res = imm;
`ifdef RF_EXEC_CARRY_CHAIN_EN
            OP_ADC: begin
                ext        = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
                res        = ext[DW-1:0];
                cout       = ext[DW];
                cout_valid = 1'b1;
            end
            OP_SBB: begin
                ext        = {1'b0, a} - {1'b0, b} - (DW+1)'(cin);
                res        = ext[DW-1:0];
                cout       = ext[DW];
                cout_valid = 1'b1;
            end
`else
            OP_MOV: res = a;
            OP_SHL1: begin
                res        = {a[DW-2:0], 1'b0};
                cout       = a[DW-1];
                cout_valid = 1'b1;
            end
`endif
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/rf_exec_ctrl.sv
// Command-driven initiator for a 2R/1W register file: IDLE -> READ -> EXEC -> WRITE, one command per 4 cycles.
// Build option RF_EXEC_CARRY_CHAIN_EN (see rf_exec_alu) changes only the opcode map.
module rf_exec_ctrl
    import rf_exec_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [AW-1:0]  cmd_dst,
    input  logic [AW-1:0]  cmd_src_a,
    input  logic [AW-1:0]  cmd_src_b,
    input  logic [DW-1:0]  cmd_imm,
    output logic [AW-1:0]  rf_raddr_a,
    output logic [AW-1:0]  rf_raddr_b,
    input  logic [DW-1:0]  rf_rdata_a,
    input  logic [DW-1:0]  rf_rdata_b,
    output logic           rf_we,
    output logic [AW-1:0]  rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic           done,
    output logic [DW-1:0]  result,
    output logic           flag_z,
    output logic           flag_c
);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [AW-1:0]  dst_q;
    logic [DW-1:0]  imm_q;
    logic [DW-1:0]  opa_q;
    logic [DW-1:0]  opb_q;

    logic [DW-1:0]  alu_res;
    logic           alu_cout;
    logic           alu_cout_valid;

    rf_exec_alu #(.DW(DW)) u_alu (
        .op         (op_q),
        .a          (opa_q),
        .b          (opb_q),
        .imm        (imm_q),
        .cin        (flag_c),
        .res        (alu_res),
        .cout       (alu_cout),
        .cout_valid (alu_cout_valid)
    );

    // Read addresses load at the handshake edge so they are valid throughout READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            op_q       <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            done       <= 1'b0;
            result     <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q       <= cmd_op;
                        dst_q      <= cmd_dst;
                        imm_q      <= cmd_imm;
                        rf_raddr_a <= cmd_src_a;
                        rf_raddr_b <= cmd_src_b;
                        cmd_ready  <= 1'b0;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    opa_q <= rf_rdata_a;
                    opb_q <= rf_rdata_b;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result   <= alu_res;
                    flag_z   <= (alu_res == '0);
                    if (alu_cout_valid) begin
                        flag_c <= alu_cout;
                    end
                    rf_wdata <= alu_res;
                    rf_waddr <= dst_q;
                    rf_we    <= 1'b1;
                    done     <= 1'b1;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    rf_we     <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Self-checking bench for rf_exec_ctrl with a behavioural 4x16 register file and an
// opcode-level reference model; honours RF_EXEC_CARRY_CHAIN_EN like the design.
module tb_rf_exec_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_dst;
    logic [1:0]  cmd_src_a;
    logic [1:0]  cmd_src_b;
    logic [15:0] cmd_imm;
    logic [1:0]  rf_raddr_a;
    logic [1:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_c;

    int checks = 0;
    int errors = 0;

    rf_exec_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_imm    (cmd_imm),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .done       (done),
        .result     (result),
        .flag_z     (flag_z),
        .flag_c     (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: combinational reads, write on rising edge.
    logic        rf_clr;
    logic [15:0] rf [4];
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 4; i++) rf[i] <= 16'h0000;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Reference model state and last expectation.
    logic [15:0] m_rf [4];
    logic        m_c;
    logic [15:0] e_res;
    logic        e_z;
    logic        e_c;

    // Observations from the last issued command.
    int          o_lat;
    int          o_wecnt;
    logic        o_rdy_bad;
    logic        o_done;
    logic [1:0]  o_waddr;
    logic [15:0] o_wdata;
    logic [15:0] o_res;
    logic        o_z;
    logic        o_c;

    task automatic model_step(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [15:0] imm);
        int unsigned a, b, r, cin;
        a   = m_rf[sa];
        b   = m_rf[sb];
        cin = m_c ? 1 : 0;
        r   = 0;
        case (op)
            3'd0: begin r = a + b; m_c = (r > 32'hFFFF); end
            3'd1: begin r = a - b; m_c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
`ifdef RF_EXEC_CARRY_CHAIN_EN
            3'd5: begin r = a + b + cin; m_c = (r > 32'hFFFF); end
            3'd7: begin r = a - b - cin; m_c = (a < b + cin); end
`else
            3'd5: r = a;
            3'd7: begin r = a * 2; m_c = (a >= 32'h8000); end
`endif
            default: r = imm;
        endcase
        e_res     = r[15:0];
        e_z       = (e_res == 16'h0000);
        e_c       = m_c;
        m_rf[dst] = e_res;
    endtask

    // Offers one command, waits for the handshake and records the resulting write-back.
    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [15:0] imm);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb; cmd_imm = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_dst = 2'($urandom); cmd_src_a = 2'($urandom);
        cmd_src_b = 2'($urandom); cmd_imm = 16'($urandom);
        o_lat = -1; o_wecnt = 0; o_rdy_bad = 1'b0; o_done = 1'b0; o_waddr = '0; o_wdata = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                o_wecnt++;
                if (o_lat < 0) begin
                    o_lat = k; o_waddr = rf_waddr; o_wdata = rf_wdata; o_done = done;
                end
            end
            if ((k <= 3 && cmd_ready !== 1'b0) || (k >= 4 && cmd_ready !== 1'b1)) o_rdy_bad = 1'b1;
        end
        o_res = result; o_z = flag_z; o_c = flag_c;
        model_step(op, dst, sa, sb, imm);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rf_clr = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0;
        for (int i = 0; i < 4; i++) m_rf[i] = 16'h0000;
        m_c = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, rf_we, done, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, result, flag_z, flag_c} !== '0)
            begin errors++; $display("FAIL reset_values ready=%b we=%b done=%b ra=%0d rb=%0d wa=%0d wd=%h res=%h z=%b c=%b, required all 0",
                cmd_ready, rf_we, done, rf_raddr_a, rf_raddr_b, rf_waddr, rf_wdata, result, flag_z, flag_c); end
        rst_n = 1'b1; rf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rf_we !== 1'b0)
            begin errors++; $display("FAIL reset_release ready=%b we=%b, required ready=1 we=0", cmd_ready, rf_we); end
    endtask

    task automatic test_ldi;
        issue(3'd6, 2'd1, 2'd2, 2'd3, 16'h1234);
        checks++;
        if (o_lat !== 3 || o_wecnt !== 1 || o_done !== 1'b1 || o_rdy_bad)
            begin errors++; $display("FAIL ldi_timing lat=%0d we_count=%0d done=%b ready_bad=%b, required lat=3 count=1 done=1 ready_bad=0",
                o_lat, o_wecnt, o_done, o_rdy_bad); end
        checks++;
        if (o_waddr !== 2'd1 || o_wdata !== 16'h1234)
            begin errors++; $display("FAIL ldi_write waddr=%0d wdata=%h, required 1/1234", o_waddr, o_wdata); end
        checks++;
        if (rf[1] !== 16'h1234) begin errors++; $display("FAIL ldi_rf r1=%h, required 1234", rf[1]); end
    endtask

    task automatic test_arith;
        issue(3'd6, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        issue(3'd6, 2'd1, 2'd0, 2'd0, 16'h0001);
        issue(3'd0, 2'd2, 2'd0, 2'd1, 16'h0000);
        checks++;
        if (o_wdata !== 16'h0000 || o_res !== 16'h0000 || o_z !== 1'b1 || o_c !== 1'b1 || rf[2] !== 16'h0000)
            begin errors++; $display("FAIL add_carry wdata=%h res=%h z=%b c=%b r2=%h, required 0000/0000/1/1/0000",
                o_wdata, o_res, o_z, o_c, rf[2]); end
        issue(3'd1, 2'd3, 2'd1, 2'd0, 16'h0000);
        checks++;
        if (o_waddr !== 2'd3 || o_wdata !== 16'h0002 || o_z !== 1'b0 || o_c !== 1'b1)
            begin errors++; $display("FAIL sub_borrow waddr=%0d wdata=%h z=%b c=%b, required 3/0002/0/1",
                o_waddr, o_wdata, o_z, o_c); end
        issue(3'd1, 2'd3, 2'd3, 2'd3, 16'h0000);
        checks++;
        if (o_wdata !== 16'h0000 || o_z !== 1'b1 || o_c !== 1'b0 || rf[3] !== 16'h0000)
            begin errors++; $display("FAIL sub_self wdata=%h z=%b c=%b r3=%h, required 0000/1/0/0000",
                o_wdata, o_z, o_c, rf[3]); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  q_op  [5];
        logic [1:0]  q_dst [5];
        logic [1:0]  q_sa  [5];
        logic [1:0]  q_sb  [5];
        logic [15:0] q_imm [5];
        int idx, nwe, cyc, last_we;
        logic hs;
        for (int i = 0; i < 5; i++) begin
            q_op[i] = 3'($urandom); q_dst[i] = 2'($urandom); q_sa[i] = 2'($urandom);
            q_sb[i] = 2'($urandom); q_imm[i] = 16'($urandom);
        end
        q_op[0] = 3'd6; q_op[1] = 3'd0; q_sa[1] = q_dst[0];
        idx = 0; nwe = 0; cyc = 0; last_we = -1;
        @(negedge clk);
        cmd_op = q_op[0]; cmd_dst = q_dst[0]; cmd_src_a = q_sa[0]; cmd_src_b = q_sb[0]; cmd_imm = q_imm[0];
        cmd_valid = 1'b1;
        while (nwe < 5 && cyc < 60) begin
            hs = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                idx++;
                if (idx < 5) begin
                    cmd_op = q_op[idx]; cmd_dst = q_dst[idx]; cmd_src_a = q_sa[idx];
                    cmd_src_b = q_sb[idx]; cmd_imm = q_imm[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
            if (rf_we === 1'b1) begin
                model_step(q_op[nwe], q_dst[nwe], q_sa[nwe], q_sb[nwe], q_imm[nwe]);
                checks++;
                if (rf_waddr !== q_dst[nwe] || rf_wdata !== e_res || result !== e_res || flag_z !== e_z || flag_c !== e_c)
                    begin errors++; $display("FAIL b2b_write[%0d] waddr=%0d wdata=%h res=%h z=%b c=%b, required %0d/%h/%h/%b/%b",
                        nwe, rf_waddr, rf_wdata, result, flag_z, flag_c, q_dst[nwe], e_res, e_res, e_z, e_c); end
                if (last_we >= 0) begin
                    checks++;
                    if (cyc - last_we !== 4)
                        begin errors++; $display("FAIL b2b_spacing[%0d] gap=%0d, required 4", nwe, cyc - last_we); end
                end
                last_we = cyc;
                nwe++;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (nwe !== 5 || idx !== 5)
            begin errors++; $display("FAIL b2b_count writes=%0d handshakes=%0d, required 5/5", nwe, idx); end
    endtask

    task automatic test_reset_mid_op;
        int n, we_seen;
        issue(3'd6, 2'd2, 2'd0, 2'd0, 16'h5A5A);
        checks++;
        if (rf[2] !== 16'h5A5A) begin errors++; $display("FAIL rst_setup r2=%h, required 5a5a", rf[2]); end
        @(negedge clk);
        cmd_op = 3'd0; cmd_dst = 2'd2; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rf_we, done, cmd_ready, result, flag_z, flag_c} !== '0)
            begin errors++; $display("FAIL rst_mid_values we=%b done=%b ready=%b res=%h z=%b c=%b, required all 0",
                rf_we, done, cmd_ready, result, flag_z, flag_c); end
        we_seen = 0;
        repeat (3) begin @(negedge clk); if (rf_we !== 1'b0) we_seen++; end
        rst_n = 1'b1;
        @(negedge clk);
        if (rf_we !== 1'b0) we_seen++;
        checks++;
        if (cmd_ready !== 1'b1 || we_seen !== 0 || rf[2] !== 16'h5A5A)
            begin errors++; $display("FAIL rst_mid_after ready=%b we_seen=%0d r2=%h, required 1/0/5a5a",
                cmd_ready, we_seen, rf[2]); end
        m_c = 1'b0;
    endtask

    task automatic test_carry_chain;
        issue(3'd6, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        issue(3'd6, 2'd1, 2'd0, 2'd0, 16'h0001);
        issue(3'd0, 2'd2, 2'd0, 2'd1, 16'h0000);
        issue(3'd5, 2'd3, 2'd1, 2'd1, 16'h0000);
`ifdef RF_EXEC_CARRY_CHAIN_EN
        checks++;
        if (o_wdata !== 16'h0003 || o_c !== 1'b0 || o_z !== 1'b0 || rf[3] !== 16'h0003)
            begin errors++; $display("FAIL adc wdata=%h c=%b z=%b r3=%h, required 0003/0/0/0003", o_wdata, o_c, o_z, rf[3]); end
`else
        checks++;
        if (o_wdata !== 16'h0001 || o_c !== 1'b1 || o_z !== 1'b0 || rf[3] !== 16'h0001)
            begin errors++; $display("FAIL mov wdata=%h c=%b z=%b r3=%h, required 0001/1/0/0001", o_wdata, o_c, o_z, rf[3]); end
`endif
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [1:0]  dst, sa, sb;
        logic [15:0] imm;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); dst = 2'($urandom); sa = 2'($urandom); sb = 2'($urandom);
            imm = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            issue(op, dst, sa, sb, imm);
            checks++;
            if (o_lat !== 3 || o_wecnt !== 1 || o_done !== 1'b1 || o_rdy_bad || o_waddr !== dst || o_wdata !== e_res)
                begin errors++; $display("FAIL rand_write[%0d] op=%0d lat=%0d cnt=%0d done=%b rdy_bad=%b waddr=%0d wdata=%h, required lat=3 cnt=1 waddr=%0d wdata=%h",
                    i, op, o_lat, o_wecnt, o_done, o_rdy_bad, o_waddr, o_wdata, dst, e_res); end
            checks++;
            if (o_res !== e_res || o_z !== e_z || o_c !== e_c)
                begin errors++; $display("FAIL rand_flags[%0d] op=%0d res=%h z=%b c=%b, required %h/%b/%b",
                    i, op, o_res, o_z, o_c, e_res, e_z, e_c); end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_arith();
        test_back_to_back();
        test_reset_mid_op();
        test_carry_chain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
